sr_ff_response_checker: RTL and testbench

- Synthesizable response checker on the output side of a clocked SR flip-flop; the complement of the stimulus driver.
- Observes the s/r drive and the q/qbar response and runs a cycle-accurate reference model alongside the DUT.
- Flags mismatches and tracks illegal-input (S=R=1) events.
- Used as a bench companion and as an on-chip self-check wrapper around flip-flop instances.

---
 rtl/ff_check_pkg.sv | 17 +
 rtl/sr_ff_ref_model.sv | 32 +++
 rtl/sr_ff_response_checker.sv | 105 ++++++++++
 tb/tb_sr_ff_response_checker.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ff_check_pkg.sv
// Shared encodings for the flip-flop response checkers: FSM state and {s,r} input codes.
package ff_check_pkg;

  localparam logic ST_UNSYNC = 1'b0;
  localparam logic ST_TRACK  = 1'b1;

  typedef enum logic {
    S_UNSYNC = ST_UNSYNC,
    S_TRACK  = ST_TRACK
  } chk_state_t;

  localparam logic [1:0] SR_HOLD = 2'b00;
  localparam logic [1:0] SR_RST  = 2'b01;
  localparam logic [1:0] SR_SET  = 2'b10;
  localparam logic [1:0] SR_ILL  = 2'b11;

endpackage

// File: rtl/sr_ff_ref_model.sv
// Combinational next-state model of a clocked SR flip-flop, including whether the
// predicted state is known.
module sr_ff_ref_model
  import ff_check_pkg::*;
(
  input  logic i_s,
  input  logic i_r,
  input  logic i_model_q,
  input  logic i_valid,
  output logic o_model_q,
  output logic o_valid
);

  always_comb begin
    o_model_q = i_model_q;
    o_valid   = i_valid;
    case ({i_s, i_r})
      SR_SET: begin
        o_model_q = 1'b1;
        o_valid   = 1'b1;
      end
      SR_RST: begin
        o_model_q = 1'b0;
        o_valid   = 1'b1;
      end
      // S=R=1 leaves the real flop undefined, so the prediction is dropped.
      SR_ILL:  o_valid = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: rtl/sr_ff_response_checker.sv
// Cycle-accurate response checker for a clocked SR flip-flop: compares q/qbar against
// a reference model and keeps saturating error/check counts.
module sr_ff_response_checker
  import ff_check_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter bit CHK_COMPL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             s,
  input  logic             r,
  input  logic             q,
  input  logic             qbar,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic             illegal_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] check_count,
  output logic             model_valid
);

  chk_state_t       r_state;
  logic             r_model_q;
  logic             r_err_pulse;
  logic             r_err_sticky;
  logic             r_illegal_pulse;
  logic             r_ill_prev;
  logic [CNT_W-1:0] r_err_count;
  logic [CNT_W-1:0] r_check_count;

  logic w_nxt_q;
  logic w_nxt_valid;
  logic w_check;
  logic w_mis;
  logic w_ill;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  sr_ff_ref_model u_model (
    .i_s       (s),
    .i_r       (r),
    .i_model_q (r_model_q),
    .i_valid   (r_state == S_TRACK),
    .o_model_q (w_nxt_q),
    .o_valid   (w_nxt_valid)
  );

  assign w_check = en && (r_state == S_TRACK);
  assign w_ill   = en && ({s, r} == SR_ILL);

  // Case-inequality lets an X/Z response count as a mismatch in simulation.
`ifdef SYNTHESIS
  assign w_mis = (q != r_model_q) || (CHK_COMPL && (qbar != ~r_model_q));
`else
  assign w_mis = (q !== r_model_q) || (CHK_COMPL && (qbar !== ~r_model_q));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_UNSYNC;
      r_model_q       <= 1'b0;
      r_err_pulse     <= 1'b0;
      r_err_sticky    <= 1'b0;
      r_illegal_pulse <= 1'b0;
      r_ill_prev      <= 1'b0;
      r_err_count     <= '0;
      r_check_count   <= '0;
    end else begin
      r_err_pulse     <= w_check && w_mis;
      // A held S=R=1 is one illegal event; only its first enabled sample strobes.
      r_illegal_pulse <= w_ill && !r_ill_prev;
      r_ill_prev      <= w_ill;
      if (en) begin
        r_state   <= w_nxt_valid ? S_TRACK : S_UNSYNC;
        r_model_q <= w_nxt_q;
      end else begin
        r_state <= S_UNSYNC;
      end
      if (clr) begin
        r_err_count   <= '0;
        r_check_count <= '0;
        r_err_sticky  <= 1'b0;
      end else if (w_check) begin
        r_check_count <= sat_inc(r_check_count);
        if (w_mis) begin
          r_err_count  <= sat_inc(r_err_count);
          r_err_sticky <= 1'b1;
        end
      end
    end
  end

  assign err_pulse     = r_err_pulse;
  assign err_sticky    = r_err_sticky;
  assign illegal_pulse = r_illegal_pulse;
  assign err_count     = r_err_count;
  assign check_count   = r_check_count;
  assign model_valid   = (r_state == S_TRACK);

endmodule

// File: tb/tb_sr_ff_response_checker.sv
// Directed bench: a behavioural SR flop with injectable faults feeds three checker
// configurations (default, no complement check, 4-bit counters).
module tb_sr_ff_response_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;
  logic clr = 1'b0;
  logic s   = 1'b0;
  logic r   = 1'b0;
  logic q, qbar;
  logic ff_q        = 1'b0;
  logic stuck0      = 1'b0;
  logic compl_fault = 1'b0;

  int n_vec  = 0;
  int n_fail = 0;

  logic       ep_a, es_a, ip_a, mv_a;
  logic [7:0] ec_a, cc_a;
  logic       ep_b, es_b, ip_b, mv_b;
  logic [7:0] ec_b, cc_b;
  logic       ep_c, es_c, ip_c, mv_c;
  logic [3:0] ec_c, cc_c;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    case ({s, r})
      2'b10:   ff_q <= 1'b1;
      2'b01:   ff_q <= 1'b0;
      default: ;
    endcase
  end

  assign q    = stuck0 ? 1'b0 : ff_q;
  assign qbar = compl_fault ? q : ~q;

  sr_ff_response_checker u_a (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .s(s), .r(r), .q(q), .qbar(qbar),
    .err_pulse(ep_a), .err_sticky(es_a), .illegal_pulse(ip_a),
    .err_count(ec_a), .check_count(cc_a), .model_valid(mv_a)
  );

  sr_ff_response_checker #(.CHK_COMPL(1'b0)) u_b (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .s(s), .r(r), .q(q), .qbar(qbar),
    .err_pulse(ep_b), .err_sticky(es_b), .illegal_pulse(ip_b),
    .err_count(ec_b), .check_count(cc_b), .model_valid(mv_b)
  );

  sr_ff_response_checker #(.CNT_W(4)) u_c (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .s(s), .r(r), .q(q), .qbar(qbar),
    .err_pulse(ep_c), .err_sticky(es_c), .illegal_pulse(ip_c),
    .err_count(ec_c), .check_count(cc_c), .model_valid(mv_c)
  );

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2;
    n_vec++;
    if ({ep_a, es_a, ip_a, mv_a, ec_a, cc_a} !== 20'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h want 0", {ep_a, es_a, ip_a, mv_a, ec_a, cc_a});
    end
    @(negedge clk);
    rst = 1'b0;
    cyc();
    n_vec++;
    if (mv_a !== 1'b0 || cc_a !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_hold00 got mv=%b cc=%0d want mv=0 cc=0", mv_a, cc_a);
    end
  endtask

  task automatic test_golden();
    logic [1:0] seq [5];
    int ill_seen;
    seq = '{2'b10, 2'b01, 2'b00, 2'b11, 2'b10};
    ill_seen = 0;
    for (int p = 0; p < 5; p++) begin
      {s, r} = seq[p];
      for (int c = 0; c < 10; c++) begin
        cyc();
        if (ip_a === 1'b1) ill_seen++;
        if (p == 3) begin
          n_vec++;
          if (mv_a !== 1'b0) begin
            n_fail++;
            $display("FAIL golden_mv_ill cyc=%0d got %b want 0", c, mv_a);
          end
        end
        if (p == 4 && c == 0) begin
          n_vec++;
          if (mv_a !== 1'b1) begin
            n_fail++;
            $display("FAIL golden_mv_resync got %b want 1", mv_a);
          end
        end
      end
    end
    n_vec++;
    if (ec_a !== 8'd0 || es_a !== 1'b0) begin
      n_fail++;
      $display("FAIL golden_errors got ec=%0d es=%b want 0/0", ec_a, es_a);
    end
    n_vec++;
    if (ill_seen != 1) begin
      n_fail++;
      $display("FAIL golden_illegal got %0d pulses want 1", ill_seen);
    end
    n_vec++;
    if (cc_a !== 8'd39) begin
      n_fail++;
      $display("FAIL golden_checks got %0d want 39", cc_a);
    end
  endtask

  task automatic test_stuck();
    int pulses;
    {s, r} = 2'b01;
    cyc();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    n_vec++;
    if (ec_a !== 8'd0 || cc_a !== 8'd0 || es_a !== 1'b0) begin
      n_fail++;
      $display("FAIL stuck_clr got ec=%0d cc=%0d es=%b want 0/0/0", ec_a, cc_a, es_a);
    end
    stuck0 = 1'b1;
    {s, r} = 2'b10;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      cyc();
      if (ep_a === 1'b1) pulses++;
      if (c == 0) begin
        n_vec++;
        if (ep_a !== 1'b0) begin
          n_fail++;
          $display("FAIL stuck_first_edge got %b want 0", ep_a);
        end
      end
    end
    stuck0 = 1'b0;
    n_vec++;
    if (pulses != 9) begin
      n_fail++;
      $display("FAIL stuck_pulses got %0d want 9", pulses);
    end
    n_vec++;
    if (ec_a !== 8'd9 || es_a !== 1'b1 || cc_a !== 8'd10) begin
      n_fail++;
      $display("FAIL stuck_counts got ec=%0d es=%b cc=%0d want 9/1/10", ec_a, es_a, cc_a);
    end
  endtask

  task automatic test_complement();
    {s, r} = 2'b00;
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    compl_fault = 1'b1;
    for (int c = 0; c < 8; c++) begin
      cyc();
      n_vec++;
      if (ep_a !== 1'b1 || ec_a !== 8'(c + 1)) begin
        n_fail++;
        $display("FAIL compl_edge%0d got ep=%b ec=%0d want 1/%0d", c, ep_a, ec_a, c + 1);
      end
    end
    compl_fault = 1'b0;
    n_vec++;
    if (ec_b !== 8'd0 || cc_b !== 8'd8 || es_b !== 1'b0) begin
      n_fail++;
      $display("FAIL compl_off got ec=%0d cc=%0d es=%b want 0/8/0", ec_b, cc_b, es_b);
    end
  endtask

  task automatic test_saturation();
    {s, r} = 2'b01;
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    stuck0 = 1'b1;
    {s, r} = 2'b10;
    for (int c = 0; c < 21; c++) cyc();
    n_vec++;
    if (ec_c !== 4'd15 || cc_c !== 4'd15 || ec_a !== 8'd20) begin
      n_fail++;
      $display("FAIL sat_reach got ec4=%0d cc4=%0d ec8=%0d want 15/15/20", ec_c, cc_c, ec_a);
    end
    cyc();
    n_vec++;
    if (ec_c !== 4'd15 || ep_c !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_hold got ec4=%0d ep=%b want 15/1", ec_c, ep_c);
    end
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    n_vec++;
    if (ec_c !== 4'd0 || cc_c !== 4'd0 || es_c !== 1'b0 || mv_c !== 1'b1 || ep_c !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_clr got ec=%0d cc=%0d es=%b mv=%b ep=%b want 0/0/0/1/1",
               ec_c, cc_c, es_c, mv_c, ep_c);
    end
    stuck0 = 1'b0;
  endtask

  task automatic test_async_reset();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    stuck0 = 1'b1;
    for (int c = 0; c < 3; c++) cyc();
    n_vec++;
    if (ec_a !== 8'd3 || mv_a !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_pre got ec=%0d mv=%b want 3/1", ec_a, mv_a);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({ep_a, es_a, ip_a, mv_a, ec_a, cc_a} !== 20'd0) begin
      n_fail++;
      $display("FAIL arst_immediate got %h want 0", {ep_a, es_a, ip_a, mv_a, ec_a, cc_a});
    end
    stuck0 = 1'b0;
    {s, r} = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cyc();
      n_vec++;
      if (mv_a !== 1'b0 || cc_a !== 8'd0) begin
        n_fail++;
        $display("FAIL arst_unsync cyc=%0d got mv=%b cc=%0d want 0/0", c, mv_a, cc_a);
      end
    end
    {s, r} = 2'b10;
    cyc();
    {s, r} = 2'b00;
    cyc();
    n_vec++;
    if (cc_a !== 8'd1 || ec_a !== 8'd0 || mv_a !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_resync got cc=%0d ec=%0d mv=%b want 1/0/1", cc_a, ec_a, mv_a);
    end
  endtask

  task automatic test_enable_gap();
    logic [1:0] gap [5];
    gap = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b01};
    {s, r} = 2'b10;
    cyc();
    en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      {s, r} = gap[c];
      cyc();
      n_vec++;
      if (mv_a !== 1'b0 || cc_a !== 8'd2 || ip_a !== 1'b0 || ec_a !== 8'd0) begin
        n_fail++;
        $display("FAIL gap_frozen cyc=%0d got mv=%b cc=%0d ip=%b ec=%0d want 0/2/0/0",
                 c, mv_a, cc_a, ip_a, ec_a);
      end
    end
    en = 1'b1;
    for (int c = 0; c < 6; c++) begin
      {s, r} = c[0] ? 2'b01 : 2'b10;
      cyc();
      n_vec++;
      if (ep_a !== 1'b0) begin
        n_fail++;
        $display("FAIL gap_resume_pulse cyc=%0d got %b want 0", c, ep_a);
      end
    end
    n_vec++;
    if (cc_a !== 8'd7 || ec_a !== 8'd0 || es_a !== 1'b0) begin
      n_fail++;
      $display("FAIL gap_resume got cc=%0d ec=%0d es=%b want 7/0/0", cc_a, ec_a, es_a);
    end
  endtask

  initial begin
    test_reset();
    test_golden();
    test_stuck();
    test_complement();
    test_saturation();
    test_async_reset();
    test_enable_gap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
